// File: rtl/rom_loader.sv
// Byte-stream ROM loader: header (A0/A1), word count, then little-endian 32-bit words.
// Define ROM_LOADER_VERIFY_EN to read back and compare every word after it is written.
module rom_loader #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        rom_we,
    output logic        rom_select,
    output logic [5:0]  rom_addr,
    output logic [31:0] rom_wd,
    input  logic [31:0] rom_rd,
    output logic        hold_rst,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef ROM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_WRITE, S_VERIFY, S_FINISH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_WRITE, S_FINISH
    } state_t;
`endif

    state_t state, state_nxt;

    logic [1:0]    byte_idx;
    logic [5:0]    last_addr;
    logic [TW-1:0] to_cnt;

    logic accept;
    logic tmo_expired;
    logic hdr_ok;
    logic cnt_ok;
    logic data_take;
    logic set_err;
    logic addr_inc;
    logic go_finish;

    assign accept      = byte_valid & byte_ready;
    assign tmo_expired = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifndef ROM_LOADER_VERIFY_EN
    logic unused_rd;
    assign unused_rd = ^rom_rd;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        rom_we     = 1'b0;
        done       = 1'b0;
        hdr_ok     = 1'b0;
        cnt_ok     = 1'b0;
        data_take  = 1'b0;
        set_err    = 1'b0;
        addr_inc   = 1'b0;
        go_finish  = 1'b0;
        case (state)
            S_IDLE: begin
                byte_ready = 1'b1;
                if (accept && byte_data[7:1] == 7'b1010_000) begin
                    hdr_ok    = 1'b1;
                    state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                byte_ready = 1'b1;
                if (accept) begin
                    if (byte_data[7:6] != 2'b00) begin
                        set_err   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_ok    = 1'b1;
                        state_nxt = S_DATA;
                    end
                end else if (tmo_expired) begin
                    set_err   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (accept) begin
                    data_take = 1'b1;
                    if (byte_idx == 2'd3) state_nxt = S_WRITE;
                end else if (tmo_expired) begin
                    set_err   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                rom_we = 1'b1;
`ifdef ROM_LOADER_VERIFY_EN
                state_nxt = S_VERIFY;
`else
                if (rom_addr == last_addr) begin
                    go_finish = 1'b1;
                    state_nxt = S_FINISH;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = S_DATA;
                end
`endif
            end
`ifdef ROM_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (rom_rd != rom_wd) begin
                    set_err   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (rom_addr == last_addr) begin
                    go_finish = 1'b1;
                    state_nxt = S_FINISH;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = S_DATA;
                end
            end
`endif
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Count 0 means 64 words; storing N-1 as a 6-bit address makes that wrap for free.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rom_select <= 1'b0;
            rom_addr   <= 6'd0;
            rom_wd     <= 32'd0;
            hold_rst   <= 1'b0;
            err        <= 1'b0;
            byte_idx   <= 2'd0;
            last_addr  <= 6'd0;
            to_cnt     <= '0;
        end else begin
            if (hdr_ok) begin
                rom_select <= byte_data[0];
                rom_addr   <= 6'd0;
                err        <= 1'b0;
                hold_rst   <= 1'b1;
                byte_idx   <= 2'd0;
            end
            if (cnt_ok)
                last_addr <= byte_data[5:0] - 6'd1;
            if (data_take) begin
                rom_wd[{byte_idx, 3'b000} +: 8] <= byte_data;
                byte_idx <= byte_idx + 2'd1;
            end
            if (addr_inc)
                rom_addr <= rom_addr + 6'd1;
            if (go_finish)
                hold_rst <= 1'b0;
            if (set_err) begin
                err      <= 1'b1;
                hold_rst <= 1'b0;
                byte_idx <= 2'd0;
            end
            if ((state == S_COUNT || state == S_DATA) && !accept)
                to_cnt <= to_cnt + TW'(1);
            else
                to_cnt <= '0;
        end
    end

endmodule
